// File: rtl/psk_pkg.sv
// rtl/psk_pkg.sv - shared types, widths and sine table for psk_sample_gen
package psk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ACC_W  = 24;
  localparam int LUT_AW = 8;
  localparam int LUT_DW = 8;

  localparam logic [LUT_DW-1:0] MIDSCALE = 8'h80;
  localparam logic [LUT_AW-1:0] PHASE_PI = 8'd128;

  // round(127*sin(pi*i/128)) for i = 0..64; the full wave is folded from this quadrant
  function automatic logic [6:0] quarter_sine(input logic [6:0] i);
    logic [6:0] q;
    q = '0;
    case (i)
      7'd0:  q = 7'd0;
      7'd1:  q = 7'd3;
      7'd2:  q = 7'd6;
      7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;
      7'd5:  q = 7'd16;
      7'd6:  q = 7'd19;
      7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;
      7'd9:  q = 7'd28;
      7'd10: q = 7'd31;
      7'd11: q = 7'd34;
      7'd12: q = 7'd37;
      7'd13: q = 7'd40;
      7'd14: q = 7'd43;
      7'd15: q = 7'd46;
      7'd16: q = 7'd49;
      7'd17: q = 7'd51;
      7'd18: q = 7'd54;
      7'd19: q = 7'd57;
      7'd20: q = 7'd60;
      7'd21: q = 7'd63;
      7'd22: q = 7'd65;
      7'd23: q = 7'd68;
      7'd24: q = 7'd71;
      7'd25: q = 7'd73;
      7'd26: q = 7'd76;
      7'd27: q = 7'd78;
      7'd28: q = 7'd81;
      7'd29: q = 7'd83;
      7'd30: q = 7'd85;
      7'd31: q = 7'd88;
      7'd32: q = 7'd90;
      7'd33: q = 7'd92;
      7'd34: q = 7'd94;
      7'd35: q = 7'd96;
      7'd36: q = 7'd98;
      7'd37: q = 7'd100;
      7'd38: q = 7'd102;
      7'd39: q = 7'd104;
      7'd40: q = 7'd106;
      7'd41: q = 7'd107;
      7'd42: q = 7'd109;
      7'd43: q = 7'd111;
      7'd44: q = 7'd112;
      7'd45: q = 7'd113;
      7'd46: q = 7'd115;
      7'd47: q = 7'd116;
      7'd48: q = 7'd117;
      7'd49: q = 7'd118;
      7'd50: q = 7'd120;
      7'd51: q = 7'd121;
      7'd52: q = 7'd122;
      7'd53: q = 7'd122;
      7'd54: q = 7'd123;
      7'd55: q = 7'd124;
      7'd56: q = 7'd125;
      7'd57: q = 7'd125;
      7'd58: q = 7'd126;
      7'd59: q = 7'd126;
      7'd60: q = 7'd126;
      7'd61: q = 7'd127;
      7'd62: q = 7'd127;
      7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = '0;
    endcase
    return q;
  endfunction

  // Offset-binary sine sample: odd quadrants mirror the index, the lower half negates
  function automatic logic [LUT_DW-1:0] sine_at(input logic [LUT_AW-1:0] k);
    logic [6:0] idx;
    logic [6:0] q;
    idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    q   = quarter_sine(idx);
    return k[7] ? (MIDSCALE - {1'b0, q}) : (MIDSCALE + {1'b0, q});
  endfunction

endpackage

// File: rtl/psk_sample_gen_sine_lut.sv
// rtl/psk_sample_gen_sine_lut.sv - dual-read registered-output 256x8 sine ROM
module sine_lut
  import psk_pkg::*;
(
  input  logic              clk,
  input  logic              i_rd,
  input  logic [LUT_AW-1:0] i_addr_a,
  input  logic [LUT_AW-1:0] i_addr_b,
  output logic [LUT_DW-1:0] o_data_a,
  output logic [LUT_DW-1:0] o_data_b
);

  logic [LUT_DW-1:0] r_data_a;
  logic [LUT_DW-1:0] r_data_b;

  always_ff @(posedge clk) begin
    if (i_rd) begin
      r_data_a <= sine_at(i_addr_a);
      r_data_b <= sine_at(i_addr_b);
    end
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;

endmodule

// File: rtl/psk_sample_gen.sv
// rtl/psk_sample_gen.sv - 2PSK carrier sample generator with reference channel
module psk_sample_gen
  import psk_pkg::*;
#(
  parameter int DIV = 4,
  parameter int SPB = 125
) (
  input  logic             clk_16M,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] ftw,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [15:0]      out_data,
  output logic             done,
  output logic             underrun
);

  localparam int DIV_W = $clog2(DIV);
  localparam int SPB_W = (SPB > 1) ? $clog2(SPB) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SPB_W-1:0] SPB_LAST = SPB_W'(SPB - 1);

  state_t             r_state;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [SPB_W-1:0]   r_samp_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_cur_bit;
  logic               r_next_bit;
  logic               r_next_full;
  logic               r_lut_valid;
  logic [15:0]        r_out_data;
  logic               r_done;
  logic               r_underrun;

  logic               w_run;
  logic               w_strobe;
  logic               w_boundary;
  logic               w_accept;
  logic [LUT_AW-1:0]  w_addr_a;
  logic [LUT_AW-1:0]  w_addr_b;
  logic [LUT_DW-1:0]  w_lut_a;
  logic [LUT_DW-1:0]  w_lut_b;

  // The cycle en is first seen high is spent entering RUN; counting starts after it
  assign w_run      = (r_state == RUN) && en;
  assign w_strobe   = w_run && (r_div_cnt == DIV_LAST);
  assign w_boundary = w_strobe && (r_samp_cnt == SPB_LAST);
  assign w_accept   = bit_valid && !r_next_full;

  assign w_addr_b = r_acc[ACC_W-1 -: LUT_AW];
  assign w_addr_a = w_addr_b + (r_cur_bit ? PHASE_PI : '0);

  sine_lut u_sine_lut (
    .clk      (clk_16M),
    .i_rd     (w_strobe),
    .i_addr_a (w_addr_a),
    .i_addr_b (w_addr_b),
    .o_data_a (w_lut_a),
    .o_data_b (w_lut_b)
  );

  always_ff @(posedge clk_16M) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= en ? RUN : IDLE;
    end
  end

  always_ff @(posedge clk_16M) begin
    if (rst || !w_run) begin
      r_div_cnt   <= '0;
      r_samp_cnt  <= '0;
      r_acc       <= '0;
      r_lut_valid <= 1'b0;
      r_done      <= 1'b0;
      r_out_data  <= {MIDSCALE, MIDSCALE};
    end else begin
      r_div_cnt   <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
      r_lut_valid <= w_strobe;
      r_done      <= r_lut_valid;
      if (r_lut_valid) begin
        r_out_data <= {w_lut_b, w_lut_a};
      end
      if (w_strobe) begin
        r_acc      <= r_acc + ftw;
        r_samp_cnt <= (r_samp_cnt == SPB_LAST) ? '0 : r_samp_cnt + SPB_W'(1);
      end
    end
  end

  // A full queue blocks accepts, so a boundary handover and an accept never collide
  always_ff @(posedge clk_16M) begin
    if (rst) begin
      r_cur_bit   <= 1'b0;
      r_next_bit  <= 1'b0;
      r_next_full <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_boundary && !r_next_full;
      if (w_boundary && r_next_full) begin
        r_cur_bit   <= r_next_bit;
        r_next_full <= 1'b0;
      end else if (w_accept) begin
        r_next_bit  <= bit_in;
        r_next_full <= 1'b1;
      end
    end
  end

  assign bit_ready = !r_next_full;
  assign out_data  = r_out_data;
  assign done      = r_done;
  assign underrun  = r_underrun;

endmodule
